data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Fixed-latency data-memory responder with byte/half/word access,
//           sign/zero extension and misaligned/illegal access flagging.
// Rev     : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic [2:0]         r_func3;
    logic [c_IDX_W+1:0] r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_lane;
    logic [31:0]        w_word;
    logic [31:0]        w_shifted;
    logic               w_commit;
    logic               w_bad;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;
    logic [31:0]        w_load;
    logic               w_unused_addr;

    // Upper address bits only select aliases of the same RAM, so they are dropped.
    assign w_unused_addr = ^addr[31:c_IDX_W+2];

    assign w_idx     = r_addr[c_IDX_W+1:2];
    assign w_lane    = r_addr[1:0];
    assign w_word    = r_mem[w_idx];
    assign w_shifted = w_word >> {w_lane, 3'b000};
    assign w_commit  = (r_state == c_WAIT) && (r_cnt == 4'd1);

    always_comb begin
        w_bad    = 1'b0;
        w_be     = 4'b0000;
        w_wlanes = r_wdata;
        w_load   = 32'd0;
        case (r_func3)
            3'b000, 3'b100: begin
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{r_wdata[7:0]}};
                w_load   = r_func3[2] ? {24'd0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            3'b001, 3'b101: begin
                w_bad    = w_lane[0];
                w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
                w_load   = r_func3[2] ? {16'd0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            3'b010: begin
                w_bad  = |w_lane;
                w_be   = 4'b1111;
                w_load = w_word;
            end
            default: w_bad = 1'b1;
        endcase
        // Unsigned variants have no meaning for stores.
        if (r_we && r_func3[2]) begin
            w_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_func3 <= func3;
                        r_addr  <= addr[c_IDX_W+1:0];
                        r_wdata <= wdata;
                        r_cnt   <= 4'(LATENCY);
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_commit) begin
                        r_state <= c_RESP;
                        r_err   <= w_bad;
                        r_rdata <= (w_bad || r_we) ? 32'd0 : w_load;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // RAM has no reset; a reset at the commit edge still suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && w_commit && r_we && !w_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wlanes[b*8 +: 8];
                end
            end
        end
    end

    assign ready = (r_state == c_IDLE);
    assign done  = (r_state == c_RESP);
    assign rdata = r_rdata;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Directed scoreboard bench for data_mem_responder.
// Rev     : 1.0
// ============================================================================
module tb_data_mem_responder;

    localparam int c_LAT = 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (c_LAT)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .we   (we),
        .func3(func3),
        .addr (addr),
        .wdata(wdata),
        .ready(ready),
        .done (done),
        .rdata(rdata),
        .err  (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        func3 = f;
        addr  = a;
        wdata = d;
    endtask

    // Called #1 after the accepting edge; returns #1 after the commit edge (RESP cycle).
    task automatic wait_resp(input string tag);
        int          n;
        logic [32:0] e;
        n = 0;
        e = '0;
        while (done !== 1'b1 && n < 40) begin
            check({tag, " ready_busy"}, 32'(ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(c_LAT));
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'(sb_q.size()));
        end else begin
            e = sb_q.pop_front();
        end
        check({tag, " rdata"}, rdata, e[31:0]);
        check({tag, " err"}, 32'(err), 32'(e[32]));
    endtask

    task automatic access(input string tag, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] er, input logic ee);
        @(negedge clk);
        check({tag, " ready_before"}, 32'(ready), 32'd1);
        drive(w, f, a, d);
        sb_q.push_back({ee, er});
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_resp(tag);
        @(posedge clk);
        #1;
        check({tag, " ready_after"}, 32'(ready), 32'd1);
        check({tag, " idle_outputs"}, {rdata[30:0], done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Word store / load
        access("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        access("lw_10", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

        // Sub-word
        access("sb_12",  1'b1, 3'b000, 32'h12, 32'h000000A5, 32'd0, 1'b0);
        access("lw_sb",  1'b0, 3'b010, 32'h10, 32'd0, 32'hDEA5BEEF, 1'b0);
        access("lb_12",  1'b0, 3'b000, 32'h12, 32'd0, 32'hFFFFFFA5, 1'b0);
        access("lbu_12", 1'b0, 3'b100, 32'h12, 32'd0, 32'h000000A5, 1'b0);
        access("lh_12",  1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFFDEA5, 1'b0);
        access("lhu_12", 1'b0, 3'b101, 32'h12, 32'd0, 32'h0000DEA5, 1'b0);
        access("lhu_10", 1'b0, 3'b101, 32'h10, 32'd0, 32'h0000BEEF, 1'b0);
        access("lb_13",  1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFFDE, 1'b0);

        // Errors
        access("lw_mis",   1'b0, 3'b010, 32'h11, 32'd0, 32'd0, 1'b1);
        access("sh_mis",   1'b1, 3'b001, 32'h13, 32'h00001234, 32'd0, 1'b1);
        access("lw_shchk", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEA5BEEF, 1'b0);
        access("st_f100",  1'b1, 3'b100, 32'h10, 32'h00000000, 32'd0, 1'b1);
        access("ld_f011",  1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1);
        access("lw_f100c", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEA5BEEF, 1'b0);

        // Address wrap
        access("sw_400", 1'b1, 3'b010, 32'h400, 32'h12345678, 32'd0, 1'b0);
        access("lw_0",   1'b0, 3'b010, 32'h0, 32'd0, 32'h12345678, 1'b0);

        // Handshake: req held with changing inputs during WAIT
        access("sw_34", 1'b1, 3'b010, 32'h34, 32'h0BADC0DE, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h30, 32'h11111111);
        sb_q.push_back({1'b0, 32'd0});
        @(posedge clk);
        #1;
        drive(1'b1, 3'b010, 32'h34, 32'h22222222);
        wait_resp("hs_held");
        drive(1'b0, 3'b010, 32'h30, 32'd0);
        sb_q.push_back({1'b0, 32'h11111111});
        @(posedge clk);
        #1;
        check("hs_not_in_resp ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        check("hs_first_idle accept", 32'(ready), 32'd0);
        wait_resp("hs_second");
        @(posedge clk);
        #1;
        access("lw_34_held", 1'b0, 3'b010, 32'h34, 32'd0, 32'h0BADC0DE, 1'b0);

        // Handshake: req pulsed only in RESP
        @(negedge clk);
        drive(1'b0, 3'b010, 32'h34, 32'd0);
        sb_q.push_back({1'b0, 32'h0BADC0DE});
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_resp("pulse_base");
        drive(1'b1, 3'b010, 32'h34, 32'h33333333);
        @(posedge clk);
        #1;
        req = 1'b0;
        check("pulse ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        check("pulse ignored", 32'(ready), 32'd1);
        check("pulse no_done", 32'(done), 32'd0);
        access("lw_34_pulse", 1'b0, 3'b010, 32'h34, 32'd0, 32'h0BADC0DE, 1'b0);

        // Reset at the commit edge
        access("sw_20", 1'b1, 3'b010, 32'h20, 32'h01020304, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (c_LAT - 1) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_commit done", 32'(done), 32'd0);
        check("rst_commit ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_commit later_done", 32'(done), 32'd0);
        access("lw_20_a", 1'b0, 3'b010, 32'h20, 32'd0, 32'h01020304, 1'b0);

        // Reset one edge after accept
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_early done", 32'(done), 32'd0);
        check("rst_early ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (c_LAT + 1) @(posedge clk);
        #1;
        check("rst_early later_done", 32'(done), 32'd0);
        access("lw_20_b", 1'b0, 3'b010, 32'h20, 32'd0, 32'h01020304, 1'b0);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
